// File: rtl/hplvds_pkg.sv
// Shared types and defaults for the HPLVDS pad-pair link sequencer.
// Holds the state encoding, the pad-control bundle and the state-to-pad decode.
package hplvds_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_BIAS     = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_IDLE     = 3'd3,
    ST_EXIT_EI  = 3'd4,
    ST_ACTIVE   = 3'd5,
    ST_SHUTDOWN = 3'd6
  } linkState_t;

  typedef struct packed {
    logic txEn;
    logic vcmEn;
    logic rtermEn;
    logic rxEn;
    logic eiDetEn;
    logic txEi;
  } padCtrl_t;

  localparam int unsigned CNT_W_DEF         = 8;
  localparam int unsigned BIAS_WAIT_CYC_DEF = 64;
  localparam int unsigned VCM_WAIT_CYC_DEF  = 32;
  localparam int unsigned EI_WAIT_CYC_DEF   = 8;
  localparam int unsigned EI_DEB_CYC_DEF    = 4;

  // Pad enables implied by each state; unused encodings fall back to the safe OFF pattern.
  function automatic padCtrl_t padDecode(input linkState_t s);
    padCtrl_t p;
    case (s)
      ST_OFF:      p = 6'b000001;
      ST_BIAS:     p = 6'b111001;
      ST_SETTLE:   p = 6'b111111;
      ST_IDLE:     p = 6'b111111;
      ST_EXIT_EI:  p = 6'b111111;
      ST_ACTIVE:   p = 6'b111110;
      ST_SHUTDOWN: p = 6'b111001;
      default:     p = 6'b000001;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/hplvds_ei_debounce.sv
// Synchronises the pad's asynchronous EI_DETECT output and debounces it into a
// stable remote-idle flag; held at 0 while the detector is disabled.
module hplvds_ei_debounce #(
  parameter int unsigned EI_DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic eiAsync,
  input  logic enable,
  output logic rxEi
);

  localparam int unsigned DEB_W = $clog2(EI_DEB_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(EI_DEB_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  logic syncA;
  logic syncB;
  logic [DEB_W-1:0] debCnt;
  logic rxEiReg;

  // Two-flop synchroniser for the asynchronous pad output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncA <= 1'b0;
      syncB <= 1'b0;
    end else begin
      syncA <= eiAsync;
      syncB <= syncA;
    end
  end

  // Count consecutive disagreeing samples; flip the flag once the run is long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debCnt  <= {DEB_W{1'b0}};
      rxEiReg <= 1'b0;
    end else if (!enable) begin
      debCnt  <= {DEB_W{1'b0}};
      rxEiReg <= 1'b0;
    end else if (syncB == rxEiReg) begin
      debCnt  <= {DEB_W{1'b0}};
      rxEiReg <= rxEiReg;
    end else if (debCnt == DEB_LAST) begin
      debCnt  <= {DEB_W{1'b0}};
      rxEiReg <= ~rxEiReg;
    end else begin
      debCnt  <= debCnt + DEB_ONE;
      rxEiReg <= rxEiReg;
    end
  end

  assign rxEi = rxEiReg;

endmodule

// File: rtl/hplvds_link_seq.sv
// Power-up / electrical-idle / shutdown sequencer for one HPLVDS TX/RX pad pair.
// Pad controls are registered from the next state so they change together with STATE_O.
module hplvds_link_seq
  import hplvds_pkg::*;
#(
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned BIAS_WAIT_CYC = BIAS_WAIT_CYC_DEF,
  parameter int unsigned VCM_WAIT_CYC  = VCM_WAIT_CYC_DEF,
  parameter int unsigned EI_WAIT_CYC   = EI_WAIT_CYC_DEF,
  parameter int unsigned EI_DEB_CYC    = EI_DEB_CYC_DEF
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       LINK_EN_I,
  input  logic       TX_IDLE_REQ_I,
  input  logic [3:0] TX_BIAS_CFG_I,
  input  logic [3:0] TX_VCM_CFG_I,
  input  logic [3:0] RTERM_TRIM_CFG_I,
  input  logic       EI_DETECT_I,
  output logic       TX_EN_O,
  output logic       TX_VCM_EN_O,
  output logic       TX_EI_O,
  output logic       RTERM_EN_O,
  output logic       RX_EN_O,
  output logic       EI_DETECT_EN_O,
  output logic [3:0] TX_BIAS_O,
  output logic [3:0] TX_VCM_O,
  output logic [3:0] RTERM_TRIM_O,
  output logic       RX_EI_O,
  output logic       LINK_READY_O,
  output logic [2:0] STATE_O
);

  localparam logic [CNT_W-1:0] BIAS_LOAD = CNT_W'(BIAS_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] VCM_LOAD  = CNT_W'(VCM_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] EI_LOAD   = CNT_W'(EI_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  linkState_t state;
  linkState_t nextState;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nextCnt;
  logic timerDone;
  padCtrl_t pad;
  logic linkReady;
  logic [3:0] biasTrim;
  logic [3:0] vcmTrim;
  logic [3:0] rtermTrim;

  assign timerDone = (cnt == CNT_ZERO);

  // Next-state selection; dropping LINK_EN outranks every other condition except in SHUTDOWN.
  always_comb begin
    nextState = state;
    case (state)
      ST_OFF: begin
        if (LINK_EN_I) nextState = ST_BIAS;
        else           nextState = ST_OFF;
      end
      ST_BIAS: begin
        if (!LINK_EN_I)     nextState = ST_OFF;
        else if (timerDone) nextState = ST_SETTLE;
        else                nextState = ST_BIAS;
      end
      ST_SETTLE: begin
        if (!LINK_EN_I)     nextState = ST_OFF;
        else if (timerDone) nextState = ST_IDLE;
        else                nextState = ST_SETTLE;
      end
      ST_IDLE: begin
        if (!LINK_EN_I)         nextState = ST_SHUTDOWN;
        else if (!TX_IDLE_REQ_I) nextState = ST_EXIT_EI;
        else                    nextState = ST_IDLE;
      end
      ST_EXIT_EI: begin
        if (!LINK_EN_I)         nextState = ST_SHUTDOWN;
        else if (TX_IDLE_REQ_I) nextState = ST_IDLE;
        else if (timerDone)     nextState = ST_ACTIVE;
        else                    nextState = ST_EXIT_EI;
      end
      ST_ACTIVE: begin
        if (!LINK_EN_I)         nextState = ST_SHUTDOWN;
        else if (TX_IDLE_REQ_I) nextState = ST_IDLE;
        else                    nextState = ST_ACTIVE;
      end
      ST_SHUTDOWN: begin
        if (timerDone) nextState = ST_OFF;
        else           nextState = ST_SHUTDOWN;
      end
      default: nextState = ST_OFF;
    endcase
  end

  // Settle timer: reload on entry to a timed state, otherwise count down and park at zero.
  always_comb begin
    nextCnt = cnt;
    if (nextState != state) begin
      case (nextState)
        ST_BIAS:     nextCnt = BIAS_LOAD;
        ST_SETTLE:   nextCnt = VCM_LOAD;
        ST_EXIT_EI:  nextCnt = EI_LOAD;
        ST_SHUTDOWN: nextCnt = EI_LOAD;
        default:     nextCnt = CNT_ZERO;
      endcase
    end else if (!timerDone) begin
      nextCnt = cnt - CNT_ONE;
    end else begin
      nextCnt = cnt;
    end
  end

  // Sequencer state, timer, registered pad controls and OFF-only trim capture.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= ST_OFF;
      cnt       <= CNT_ZERO;
      pad       <= padDecode(ST_OFF);
      linkReady <= 1'b0;
      biasTrim  <= 4'h0;
      vcmTrim   <= 4'h0;
      rtermTrim <= 4'h0;
    end else begin
      state     <= nextState;
      cnt       <= nextCnt;
      pad       <= padDecode(nextState);
      linkReady <= (nextState == ST_ACTIVE);
      if (state == ST_OFF) begin
        biasTrim  <= TX_BIAS_CFG_I;
        vcmTrim   <= TX_VCM_CFG_I;
        rtermTrim <= RTERM_TRIM_CFG_I;
      end else begin
        biasTrim  <= biasTrim;
        vcmTrim   <= vcmTrim;
        rtermTrim <= rtermTrim;
      end
    end
  end

  hplvds_ei_debounce #(
    .EI_DEB_CYC(EI_DEB_CYC)
  ) uEiDebounce (
    .clk    (CLK_I),
    .rst    (RST_I),
    .eiAsync(EI_DETECT_I),
    .enable (pad.eiDetEn),
    .rxEi   (RX_EI_O)
  );

  assign TX_EN_O        = pad.txEn;
  assign TX_VCM_EN_O    = pad.vcmEn;
  assign RTERM_EN_O     = pad.rtermEn;
  assign RX_EN_O        = pad.rxEn;
  assign EI_DETECT_EN_O = pad.eiDetEn;
  assign TX_EI_O        = pad.txEi;
  assign TX_BIAS_O      = biasTrim;
  assign TX_VCM_O       = vcmTrim;
  assign RTERM_TRIM_O   = rtermTrim;
  assign LINK_READY_O   = linkReady;
  assign STATE_O        = state;

endmodule

// File: tb/tb_hplvds_link_seq.sv
// Self-checking bench for hplvds_link_seq: directed sequence with literal checkpoints,
// then randomized traffic compared every cycle against a duration-based reference model.
module tb_hplvds_link_seq;

  localparam int BIAS_CYC = 64;
  localparam int VCM_CYC  = 32;
  localparam int EI_CYC   = 8;
  localparam int DEB_CYC  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       linkEn;
  logic       idleReq;
  logic [3:0] biasCfg;
  logic [3:0] vcmCfg;
  logic [3:0] rtermCfg;
  logic       eiDet;
  logic       txEn, txVcmEn, txEi, rtermEn, rxEn, eiDetEn;
  logic [3:0] txBias, txVcm, rtermTrim;
  logic       rxEi, linkReady;
  logic [2:0] stateOut;

  int checks = 0;
  int errors = 0;

  // Reference model: state id, cycles spent in it, trims, remote-idle flag
  int         mState;
  int         mElapsed;
  logic [3:0] mBias, mVcm, mRterm;
  logic       mRx;
  int         mStreak;
  logic [1:0] eiDelay;

  hplvds_link_seq dut (
    .CLK_I           (clk),
    .RST_I           (rst),
    .LINK_EN_I       (linkEn),
    .TX_IDLE_REQ_I   (idleReq),
    .TX_BIAS_CFG_I   (biasCfg),
    .TX_VCM_CFG_I    (vcmCfg),
    .RTERM_TRIM_CFG_I(rtermCfg),
    .EI_DETECT_I     (eiDet),
    .TX_EN_O         (txEn),
    .TX_VCM_EN_O     (txVcmEn),
    .TX_EI_O         (txEi),
    .RTERM_EN_O      (rtermEn),
    .RX_EN_O         (rxEn),
    .EI_DETECT_EN_O  (eiDetEn),
    .TX_BIAS_O       (txBias),
    .TX_VCM_O        (txVcm),
    .RTERM_TRIM_O    (rtermTrim),
    .RX_EI_O         (rxEi),
    .LINK_READY_O    (linkReady),
    .STATE_O         (stateOut)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] padPattern(input int s);
    case (s)
      1:       return 6'b111001;
      2, 3, 4: return 6'b111111;
      5:       return 6'b111110;
      6:       return 6'b111001;
      default: return 6'b000001;
    endcase
  endfunction

  task automatic modelReset();
    mState   = 0;
    mElapsed = 0;
    mBias    = 4'h0;
    mVcm     = 4'h0;
    mRterm   = 4'h0;
    mRx      = 1'b0;
    mStreak  = 0;
    eiDelay  = 2'b00;
  endtask

  task automatic modelStep();
    int   ns;
    logic detOn;
    logic sample;
    detOn  = (mState >= 2 && mState <= 5);
    sample = eiDelay[1];
    ns = mState;
    case (mState)
      0: if (linkEn) ns = 1;
      1: if (!linkEn) ns = 0; else if (mElapsed == BIAS_CYC) ns = 2;
      2: if (!linkEn) ns = 0; else if (mElapsed == VCM_CYC) ns = 3;
      3: if (!linkEn) ns = 6; else if (!idleReq) ns = 4;
      4: if (!linkEn) ns = 6; else if (idleReq) ns = 3; else if (mElapsed == EI_CYC) ns = 5;
      5: if (!linkEn) ns = 6; else if (idleReq) ns = 3;
      6: if (mElapsed == EI_CYC) ns = 0;
      default: ns = 0;
    endcase
    if (mState == 0) begin
      mBias  = biasCfg;
      mVcm   = vcmCfg;
      mRterm = rtermCfg;
    end
    mElapsed = (ns != mState) ? 1 : mElapsed + 1;
    mState   = ns;
    if (!detOn) begin
      mRx = 1'b0;
      mStreak = 0;
    end else if (sample == mRx) begin
      mStreak = 0;
    end else begin
      mStreak++;
      if (mStreak == DEB_CYC) begin
        mRx = ~mRx;
        mStreak = 0;
      end
    end
    eiDelay = {eiDelay[0], eiDet};
  endtask

  task automatic compareModel();
    logic [22:0] act;
    logic [22:0] exp;
    act = {txEn, txVcmEn, rtermEn, rxEn, eiDetEn, txEi, txBias, txVcm, rtermTrim,
           rxEi, linkReady, stateOut};
    exp = {padPattern(mState), mBias, mVcm, mRterm, mRx, (mState == 5), 3'(mState)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model t=%0t actual=%h expected=%h", $time, act, exp);
    end
  endtask

  task automatic checkLit(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) modelReset();
      else     modelStep();
      #1;
      compareModel();
    end
  endtask

  initial begin
    rst = 1'b1; linkEn = 1'b0; idleReq = 1'b1; eiDet = 1'b0;
    biasCfg = 4'h3; vcmCfg = 4'h5; rtermCfg = 4'h9;
    modelReset();
    step(2);
    checkLit("reset_state", {1'b0, stateOut}, 4'h0);
    checkLit("reset_txei", {3'b000, txEi}, 4'h1);
    checkLit("reset_txen", {3'b000, txEn}, 4'h0);
    rst = 1'b0;
    step(2);

    // Power-up timing
    linkEn = 1'b1;
    step(1);
    checkLit("bias_entry", {1'b0, stateOut}, 4'h1);
    checkLit("txen_c1", {3'b000, txEn}, 4'h1);
    checkLit("rterm_c1", {3'b000, rtermEn}, 4'h1);
    checkLit("bias_trim", txBias, 4'h3);
    step(63);
    checkLit("bias_c64", {1'b0, stateOut}, 4'h1);
    step(1);
    checkLit("settle_c65", {1'b0, stateOut}, 4'h2);
    step(31);
    checkLit("settle_c96", {1'b0, stateOut}, 4'h2);
    step(1);
    checkLit("idle_c97", {1'b0, stateOut}, 4'h3);

    // Exit electrical idle
    idleReq = 1'b0;
    step(8);
    checkLit("exit_ei_c8", {1'b0, stateOut}, 4'h4);
    checkLit("not_ready_c8", {3'b000, linkReady}, 4'h0);
    step(1);
    checkLit("ready", {3'b000, linkReady}, 4'h1);
    checkLit("txei_low", {3'b000, txEi}, 4'h0);

    // EI debounce: short pulse rejected, long level accepted after 2+4 cycles
    eiDet = 1'b1; step(3);
    eiDet = 1'b0; step(8);
    checkLit("ei_pulse_reject", {3'b000, rxEi}, 4'h0);
    eiDet = 1'b1; step(5);
    checkLit("ei_c5", {3'b000, rxEi}, 4'h0);
    step(1);
    checkLit("ei_c6", {3'b000, rxEi}, 4'h1);
    eiDet = 1'b0; step(8);

    // Trim change while up is frozen
    biasCfg = 4'hA; step(2);
    checkLit("trim_frozen", txBias, 4'h3);

    idleReq = 1'b1; step(1);
    checkLit("req_txei", {3'b000, txEi}, 4'h1);
    checkLit("req_idle", {1'b0, stateOut}, 4'h3);
    idleReq = 1'b0; step(9);
    checkLit("ready_again", {3'b000, linkReady}, 4'h1);

    // Shutdown from ACTIVE
    linkEn = 1'b0; step(1);
    checkLit("shut_state", {1'b0, stateOut}, 4'h6);
    checkLit("shut_rxen", {3'b000, rxEn}, 4'h0);
    checkLit("shut_txei", {3'b000, txEi}, 4'h1);
    step(7);
    checkLit("shut_c8", {1'b0, stateOut}, 4'h6);
    step(1);
    checkLit("off_after_shut", {1'b0, stateOut}, 4'h0);
    checkLit("trim_old_in_off", txBias, 4'h3);
    step(1);
    checkLit("trim_new", txBias, 4'hA);

    // Drop in SETTLE
    linkEn = 1'b1; step(65);
    checkLit("settle_again", {1'b0, stateOut}, 4'h2);
    linkEn = 1'b0; step(1);
    checkLit("settle_drop_off", {1'b0, stateOut}, 4'h0);

    // Asynchronous reset mid-BIAS
    linkEn = 1'b1; step(10);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkLit("rst_state", {1'b0, stateOut}, 4'h0);
    checkLit("rst_txei", {3'b000, txEi}, 4'h1);
    checkLit("rst_txen", {3'b000, txEn}, 4'h0);
    checkLit("rst_trim", txBias, 4'h0);
    compareModel();
    step(2);
    rst = 1'b0;
    step(1);
    checkLit("restart_bias", {1'b0, stateOut}, 4'h1);

    // Randomized traffic
    for (int c = 0; c < 8000; c++) begin
      if (linkEn ? ($urandom_range(399, 0) == 0) : ($urandom_range(19, 0) == 0)) linkEn = ~linkEn;
      if ($urandom_range(39, 0) == 0) idleReq = ~idleReq;
      if ($urandom_range(5, 0) == 0) eiDet = ~eiDet;
      if ($urandom_range(29, 0) == 0) begin
        biasCfg  = 4'($urandom);
        vcmCfg   = 4'($urandom);
        rtermCfg = 4'($urandom);
      end
      if (!rst && $urandom_range(1999, 0) == 0) begin
        #2 rst = 1'b1;
        #1;
        modelReset();
        compareModel();
      end else begin
        rst = 1'b0;
      end
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
